// File: rtl/mem_bus_pkg.sv
// Shared definitions for the multiplexed memory-bus sequencer:
// state encoding and the pin values driven while the bus is idle.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR_H = 2'd1,
    ADDR_L = 2'd2,
    DATA   = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_BUS_ADDR = 8'h00;
  localparam logic [7:0] IDLE_BUS_DOUT = 8'h00;
  localparam logic [7:0] IDLE_BUS_OE   = 8'h00;
  localparam logic       IDLE_RW_N     = 1'b1;

  localparam logic [7:0] BUS_OE_DRIVE  = 8'hFF;

endpackage

// File: rtl/mem_bus_wait_timer.sv
// Stall counter for the DATA phase; only built when MEM_BUS_WAIT_EN is defined.
// expire flags the stalled cycle that reaches TIMEOUT_CYCLES.
module mem_bus_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clear,
  output logic expire
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (stall) begin
      count <= count + 8'd1;
    end
  end

  // The current stalled cycle is the TIMEOUT_CYCLES-th one when count is one short.
  assign expire = stall && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_sequencer.sv
// Sequences one core access onto an 8-bit multiplexed bus: ADDR_H, ADDR_L, DATA.
// Define MEM_BUS_WAIT_EN to add ext_rdy wait states with a timeout error completion.
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [7:0]  bus_addr,
  output logic        ale_h,
  output logic        ale_l,
  output logic        rw_n,
  output logic [7:0]  bus_dout,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_din,
  input  logic        ext_rdy
);

  state_t     state;
  logic       we_q;
  logic [7:0] addr_lo_q;
  logic [7:0] wdata_q;
  logic       data_done;
  logic       data_timeout;

`ifdef MEM_BUS_WAIT_EN
  logic stall;

  assign stall     = (state == DATA) && !ext_rdy;
  assign data_done = ext_rdy || data_timeout;

  mem_bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .stall  (stall),
    .clear  ((state == DATA) && data_done),
    .expire (data_timeout)
  );

  // err is raised only on the completing edge, so it can never outlive ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= (state == DATA) && data_timeout;
    end
  end
`else
  logic unused_ext_rdy;

  assign unused_ext_rdy = ext_rdy;
  assign data_done      = 1'b1;
  assign data_timeout   = 1'b0;
  assign err            = 1'b0;
`endif

  // NOTE: reset is sampled synchronously and all state uses non-blocking
  // assignments so every output is a clean register at the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack       <= 1'b0;
      rdata     <= 8'h00;
      busy      <= 1'b0;
      we_q      <= 1'b0;
      addr_lo_q <= 8'h00;
      wdata_q   <= 8'h00;
      bus_addr  <= IDLE_BUS_ADDR;
      ale_h     <= 1'b0;
      ale_l     <= 1'b0;
      rw_n      <= IDLE_RW_N;
      bus_dout  <= IDLE_BUS_DOUT;
      bus_oe    <= IDLE_BUS_OE;
    end else begin
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q      <= we;
            addr_lo_q <= addr[7:0];
            wdata_q   <= wdata;
            busy      <= 1'b1;
            bus_addr  <= addr[15:8];
            ale_h     <= 1'b1;
            state     <= ADDR_H;
          end
        end
        ADDR_H: begin
          ale_h    <= 1'b0;
          ale_l    <= 1'b1;
          bus_addr <= addr_lo_q;
          state    <= ADDR_L;
        end
        ADDR_L: begin
          ale_l <= 1'b0;
          if (we_q) begin
            bus_dout <= wdata_q;
            bus_oe   <= BUS_OE_DRIVE;
            rw_n     <= 1'b0;
          end else begin
            bus_oe   <= IDLE_BUS_OE;
          end
          state <= DATA;
        end
        DATA: begin
          // Pins hold their DATA values until the access completes.
          if (data_done) begin
            ack      <= 1'b1;
            busy     <= 1'b0;
            if (!we_q) begin
              rdata <= data_timeout ? 8'h00 : bus_din;
            end
            bus_addr <= IDLE_BUS_ADDR;
            rw_n     <= IDLE_RW_N;
            bus_dout <= IDLE_BUS_DOUT;
            bus_oe   <= IDLE_BUS_OE;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
